// File: rtl/w0rm_stream_scoreboard.sv
// rtl/w0rm_stream_scoreboard.sv - in-order expected/actual result scoreboard
// Expected entries queue in a FIFO; each actual result is checked against the head, with timeout and first-error capture.
module w0rm_stream_scoreboard #(
   parameter int DATA_WIDTH  = 32,
   parameter int FLAGS_WIDTH = 4,
   parameter int DEPTH       = 16,
   parameter int CNT_WIDTH   = 16,
   parameter int TIMEOUT     = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   exp_valid,
   output logic                   exp_ready,
   input  logic [DATA_WIDTH-1:0]  exp_data,
   input  logic [FLAGS_WIDTH-1:0] exp_flags,
   input  logic [FLAGS_WIDTH-1:0] exp_flags_mask,
   input  logic                   exp_last,
   input  logic                   act_valid,
   input  logic [DATA_WIDTH-1:0]  act_data,
   input  logic [FLAGS_WIDTH-1:0] act_flags,
   output logic                   done,
   output logic                   error,
   output logic [2:0]             err_code,
   output logic [CNT_WIDTH-1:0]   match_count,
   output logic [CNT_WIDTH-1:0]   mismatch_count,
   output logic [CNT_WIDTH-1:0]   first_err_index,
   output logic [DATA_WIDTH-1:0]  first_err_exp,
   output logic [DATA_WIDTH-1:0]  first_err_act
);

   localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   localparam logic [2:0] E_DATA    = 3'd1;
   localparam logic [2:0] E_FLAGS   = 3'd2;
   localparam logic [2:0] E_ORPHAN  = 3'd3;
   localparam logic [2:0] E_TIMEOUT = 3'd4;
   localparam logic [2:0] E_STRAY   = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t state, state_d;

   logic [DATA_WIDTH-1:0]  mem_data [DEPTH];
   logic [FLAGS_WIDTH-1:0] mem_flags[DEPTH];
   logic [FLAGS_WIDTH-1:0] mem_mask [DEPTH];

   logic [AW-1:0]        rd_ptr, wr_ptr;
   logic [CW-1:0]        count;
   logic [TW-1:0]        timer;
   logic [CNT_WIDTH-1:0] cmp_idx;

   logic                   empty, full, active;
   logic                   push, act_in, cmp, orphan, stray, pop, store;
   logic                   tick, timeout, data_ok, flags_ok, match_hit;
   logic [DATA_WIDTH-1:0]  head_data;
   logic [FLAGS_WIDTH-1:0] head_flags, head_mask;
   logic                   err_hit;
   logic [2:0]             err_code_d;
   logic [DATA_WIDTH-1:0]  err_exp_d, err_act_d;

   assign empty     = (count == '0);
   assign full      = (count == FULL_CNT);
   assign active    = (state == S_RUN) || (state == S_DRAIN);
   assign exp_ready = (state == S_RUN) && !full;

   // start discards every same-cycle push and result
   assign push   = exp_valid && exp_ready && !start;
   assign act_in = act_valid && !start;
   assign cmp    = act_in && active && (!empty || push);
   assign orphan = act_in && active && empty && !push;
   assign stray  = act_in && !active;
   assign pop    = cmp && !empty;
   // an entry consumed by a same-cycle bypass compare is never stored
   assign store  = push && !(cmp && empty);

   assign head_data  = empty ? exp_data       : mem_data[rd_ptr];
   assign head_flags = empty ? exp_flags      : mem_flags[rd_ptr];
   assign head_mask  = empty ? exp_flags_mask : mem_mask[rd_ptr];

   assign data_ok   = (act_data == head_data);
   assign flags_ok  = (((act_flags ^ head_flags) & head_mask) == '0);
   assign match_hit = cmp && data_ok && flags_ok;

   assign tick    = active && !empty && !act_valid;
   assign timeout = (TIMEOUT != 0) && !start && tick && (timer == TO_LAST);

   // At most one error source can fire per cycle; the chain only orders data over flags.
   always_comb begin
      err_hit    = 1'b0;
      err_code_d = '0;
      err_exp_d  = '0;
      err_act_d  = '0;
      if (cmp && !data_ok) begin
         err_hit    = 1'b1;
         err_code_d = E_DATA;
         err_exp_d  = head_data;
         err_act_d  = act_data;
      end else if (cmp && !flags_ok) begin
         err_hit    = 1'b1;
         err_code_d = E_FLAGS;
         err_exp_d  = head_data;
         err_act_d  = act_data;
      end else if (orphan) begin
         err_hit    = 1'b1;
         err_code_d = E_ORPHAN;
         err_act_d  = act_data;
      end else if (stray) begin
         err_hit    = 1'b1;
         err_code_d = E_STRAY;
         err_act_d  = act_data;
      end else if (timeout) begin
         err_hit    = 1'b1;
         err_code_d = E_TIMEOUT;
      end
   end

   always_comb begin
      state_d = state;
      if (start) begin
         state_d = S_RUN;
      end else begin
         case (state)
            S_RUN: begin
               if (timeout)
                  state_d = S_DONE;
               else if (push && exp_last)
                  state_d = S_DRAIN;
            end
            S_DRAIN: begin
               if (timeout || (empty && !cmp))
                  state_d = S_DONE;
            end
            default: state_d = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_d;
         done  <= (state_d == S_DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (store) begin
         mem_data[wr_ptr]  <= exp_data;
         mem_flags[wr_ptr] <= exp_flags;
         mem_mask[wr_ptr]  <= exp_flags_mask;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         count           <= '0;
         timer           <= '0;
         cmp_idx         <= '0;
         error           <= 1'b0;
         err_code        <= '0;
         match_count     <= '0;
         mismatch_count  <= '0;
         first_err_index <= '0;
         first_err_exp   <= '0;
         first_err_act   <= '0;
      end else if (start) begin
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         count           <= '0;
         timer           <= '0;
         cmp_idx         <= '0;
         error           <= 1'b0;
         err_code        <= '0;
         match_count     <= '0;
         mismatch_count  <= '0;
         first_err_index <= '0;
         first_err_exp   <= '0;
         first_err_act   <= '0;
      end else begin
         if (timeout) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (store)
               wr_ptr <= wr_ptr + 1'b1;
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
            if (store && !pop)
               count <= count + 1'b1;
            else if (pop && !store)
               count <= count - 1'b1;
         end

         if (cmp || timeout)
            timer <= '0;
         else if (tick)
            timer <= timer + 1'b1;

         if ((cmp || orphan) && (cmp_idx != '1))
            cmp_idx <= cmp_idx + 1'b1;
         if (match_hit && (match_count != '1))
            match_count <= match_count + 1'b1;
         if (err_hit && (mismatch_count != '1))
            mismatch_count <= mismatch_count + 1'b1;

         if (err_hit && !error) begin
            error           <= 1'b1;
            err_code        <= err_code_d;
            first_err_index <= cmp_idx;
            first_err_exp   <= err_exp_d;
            first_err_act   <= err_act_d;
         end
      end
   end

endmodule

// File: tb/tb_w0rm_stream_scoreboard.sv
// tb/tb_w0rm_stream_scoreboard.sv - directed bench for w0rm_stream_scoreboard
module tb_w0rm_stream_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        exp_valid;
   logic        exp_ready;
   logic [31:0] exp_data;
   logic [3:0]  exp_flags;
   logic [3:0]  exp_flags_mask;
   logic        exp_last;
   logic        act_valid;
   logic [31:0] act_data;
   logic [3:0]  act_flags;
   logic        done;
   logic        error;
   logic [2:0]  err_code;
   logic [15:0] match_count;
   logic [15:0] mismatch_count;
   logic [15:0] first_err_index;
   logic [31:0] first_err_exp;
   logic [31:0] first_err_act;

   always #5 clk = ~clk;

   w0rm_stream_scoreboard #(
      .DATA_WIDTH (32),
      .FLAGS_WIDTH(4),
      .DEPTH      (16),
      .CNT_WIDTH  (16),
      .TIMEOUT    (10)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .exp_valid      (exp_valid),
      .exp_ready      (exp_ready),
      .exp_data       (exp_data),
      .exp_flags      (exp_flags),
      .exp_flags_mask (exp_flags_mask),
      .exp_last       (exp_last),
      .act_valid      (act_valid),
      .act_data       (act_data),
      .act_flags      (act_flags),
      .done           (done),
      .error          (error),
      .err_code       (err_code),
      .match_count    (match_count),
      .mismatch_count (mismatch_count),
      .first_err_index(first_err_index),
      .first_err_exp  (first_err_exp),
      .first_err_act  (first_err_act)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] ed;
      logic [3:0]  ef;
      logic [3:0]  em;
      logic [31:0] ad;
      logic [3:0]  af;
      logic [2:0]  code;
   } vec_t;

   vec_t vt[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
      end
   endtask

   task automatic clr_in();
      start          = 1'b0;
      exp_valid      = 1'b0;
      exp_data       = '0;
      exp_flags      = '0;
      exp_flags_mask = '0;
      exp_last       = 1'b0;
      act_valid      = 1'b0;
      act_data       = '0;
      act_flags      = '0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic push(input logic [31:0] d, input logic [3:0] f, input logic [3:0] m, input logic last);
      exp_valid      = 1'b1;
      exp_data       = d;
      exp_flags      = f;
      exp_flags_mask = m;
      exp_last       = last;
   endtask

   task automatic result(input logic [31:0] d, input logic [3:0] f);
      act_valid = 1'b1;
      act_data  = d;
      act_flags = f;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_done"},      32'(done), 0);
      chk({tag, "_error"},     32'(error), 0);
      chk({tag, "_err_code"},  32'(err_code), 0);
      chk({tag, "_match"},     32'(match_count), 0);
      chk({tag, "_mismatch"},  32'(mismatch_count), 0);
      chk({tag, "_index"},     32'(first_err_index), 0);
      chk({tag, "_exp"},       first_err_exp, 0);
      chk({tag, "_act"},       first_err_act, 0);
      chk({tag, "_exp_ready"}, 32'(exp_ready), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int pushed, got, cyc, n;
      logic saw_full;

      vt[0] = '{32'h0000_0001, 4'b0000, 4'b1111, 32'h0000_0001, 4'b0000, 3'd0};
      vt[1] = '{32'hA5A5_5A5A, 4'b1010, 4'b1000, 32'hA5A5_5A5A, 4'b1001, 3'd0};
      vt[2] = '{32'hA5A5_5A5A, 4'b1010, 4'b0001, 32'hA5A5_5A5A, 4'b1001, 3'd2};
      vt[3] = '{32'hDEAD_BEEF, 4'b0011, 4'b1111, 32'hDEAD_BEEE, 4'b0011, 3'd1};
      vt[4] = '{32'h1234_5678, 4'b0000, 4'b1111, 32'h1234_5679, 4'b1111, 3'd1};
      vt[5] = '{32'hCAFE_F00D, 4'b1111, 4'b0000, 32'hCAFE_F00D, 4'b0000, 3'd0};
      vt[6] = '{32'h0000_0000, 4'b0000, 4'b0000, 32'hFFFF_FFFF, 4'b0000, 3'd1};
      vt[7] = '{32'h8000_0000, 4'b0100, 4'b1111, 32'h8000_0000, 4'b0110, 3'd2};

      clr_in();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;
      tick();

      // result arriving while idle
      result(32'h77, 4'h0);
      tick();
      clr_in();
      chk("idle_err_code", 32'(err_code), 5);
      chk("idle_error", 32'(error), 1);
      chk("idle_mismatch", 32'(mismatch_count), 1);
      chk("idle_act", first_err_act, 32'h77);
      chk("idle_exp", first_err_exp, 0);
      pulse_start();
      chk("start_clears_error", 32'(error), 0);
      chk("start_clears_mismatch", 32'(mismatch_count), 0);
      chk("start_exp_ready", 32'(exp_ready), 1);

      // single-entry bypass runs from the vector table
      for (int i = 0; i < 8; i++) begin
         pulse_start();
         push(vt[i].ed, vt[i].ef, vt[i].em, 1'b1);
         result(vt[i].ad, vt[i].af);
         tick();
         clr_in();
         tick();
         chk($sformatf("vec%0d_done", i), 32'(done), 1);
         chk($sformatf("vec%0d_err_code", i), 32'(err_code), 32'(vt[i].code));
         chk($sformatf("vec%0d_error", i), 32'(error), (vt[i].code != 0) ? 1 : 0);
         chk($sformatf("vec%0d_match", i), 32'(match_count), (vt[i].code == 0) ? 1 : 0);
         chk($sformatf("vec%0d_mismatch", i), 32'(mismatch_count), (vt[i].code != 0) ? 1 : 0);
         if (vt[i].code != 0) begin
            chk($sformatf("vec%0d_index", i), 32'(first_err_index), 0);
            chk($sformatf("vec%0d_exp", i), first_err_exp, vt[i].ed);
            chk($sformatf("vec%0d_act", i), first_err_act, vt[i].ad);
         end
      end

      // latency-0 bypass stream of 8
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         push(32'(i), 4'(i), 4'b1111, (i == 7));
         result(32'(i), 4'(i));
         chk($sformatf("byp_ready%0d", i), 32'(exp_ready), 1);
         tick();
      end
      clr_in();
      tick();
      chk("byp_done", 32'(done), 1);
      chk("byp_match", 32'(match_count), 8);
      chk("byp_mismatch", 32'(mismatch_count), 0);
      chk("byp_error", 32'(error), 0);

      // 20 entries, one result every 5 cycles, fills the 16-deep FIFO
      pulse_start();
      pushed   = 0;
      got      = 0;
      cyc      = 0;
      saw_full = 1'b0;
      while (got < 20 && cyc < 400) begin
         clr_in();
         if (pushed < 20)
            push(32'h1000 + 32'(pushed), 4'h0, 4'hF, (pushed == 19));
         if ((cyc % 5) == 4 && got < pushed)
            result(32'h1000 + 32'(got), 4'h0);
         if (pushed < 20) begin
            chk("lat_ready", 32'(exp_ready), ((pushed - got) < 16) ? 1 : 0);
            if (!exp_ready)
               saw_full = 1'b1;
         end
         n = (exp_valid && exp_ready) ? 1 : 0;
         tick();
         pushed += n;
         if (act_valid)
            got++;
         cyc++;
      end
      clr_in();
      chk("lat_all_results", 32'(got), 20);
      tick();
      chk("lat_saw_full", 32'(saw_full), 1);
      chk("lat_done", 32'(done), 1);
      chk("lat_match", 32'(match_count), 20);
      chk("lat_mismatch", 32'(mismatch_count), 0);
      chk("lat_error", 32'(error), 0);

      // data mismatch on entry 3 of 6, all queued before results
      pulse_start();
      for (int i = 0; i < 6; i++) begin
         push((i == 3) ? 32'hDEAD_BEEF : 32'h100 + 32'(i), 4'h0, 4'hF, (i == 5));
         tick();
      end
      clr_in();
      for (int i = 0; i < 6; i++) begin
         result((i == 3) ? 32'hDEAD_BEEE : 32'h100 + 32'(i), 4'h0);
         tick();
      end
      clr_in();
      tick();
      chk("dm_done", 32'(done), 1);
      chk("dm_err_code", 32'(err_code), 1);
      chk("dm_index", 32'(first_err_index), 3);
      chk("dm_exp", first_err_exp, 32'hDEAD_BEEF);
      chk("dm_act", first_err_act, 32'hDEAD_BEEE);
      chk("dm_match", 32'(match_count), 5);
      chk("dm_mismatch", 32'(mismatch_count), 1);

      // timeout with one pending entry
      pulse_start();
      push(32'hABC, 4'h0, 4'hF, 1'b1);
      tick();
      clr_in();
      n = 0;
      while (!done && n < 30) begin
         tick();
         n++;
      end
      chk("to_cycles", 32'(n), 10);
      chk("to_done", 32'(done), 1);
      chk("to_err_code", 32'(err_code), 4);
      chk("to_exp", first_err_exp, 0);
      chk("to_act", first_err_act, 0);
      chk("to_mismatch", 32'(mismatch_count), 1);
      chk("to_match", 32'(match_count), 0);

      // orphan result before any push
      pulse_start();
      result(32'h55, 4'h0);
      tick();
      clr_in();
      chk("orph_err_code", 32'(err_code), 3);
      chk("orph_act", first_err_act, 32'h55);
      chk("orph_exp", first_err_exp, 0);
      chk("orph_index", 32'(first_err_index), 0);
      chk("orph_mismatch", 32'(mismatch_count), 1);
      chk("orph_not_done", 32'(done), 0);

      // asynchronous reset while draining with 4 entries pending
      pulse_start();
      push(32'h1, 4'h0, 4'hF, 1'b0);
      result(32'h2, 4'h0);
      tick();
      clr_in();
      for (int i = 0; i < 4; i++) begin
         push(32'h200 + 32'(i), 4'h0, 4'hF, (i == 3));
         tick();
      end
      clr_in();
      chk("rst_pre_error", 32'(error), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("midrst");
      #1;
      rst_n = 1'b1;
      tick();
      pulse_start();
      push(32'h9, 4'h3, 4'hF, 1'b1);
      result(32'h9, 4'h3);
      tick();
      clr_in();
      tick();
      chk("post_rst_done", 32'(done), 1);
      chk("post_rst_match", 32'(match_count), 1);
      chk("post_rst_error", 32'(error), 0);
      chk("post_rst_mismatch", 32'(mismatch_count), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/w0rm_stream_scoreboard.md
Name: w0rm_stream_scoreboard

Overview:
- Synthesizable in-order scoreboard for core-unit benches (ALU, shifter, multiplier) and for on-FPGA self-test.
- A stimulus source pushes expected results and flags into an internal FIFO. The unit under test emits results with arbitrary latency; each result is compared against the FIFO head.
- Generalises the fixed single-cycle compare to multi-cycle latency with width and depth parameters, flag checking with a per-entry mask, timeout detection, and first-error capture.

Parameters:
DATA_WIDTH, 32, result width
FLAGS_WIDTH, 4, flag vector width (Z,N,V,C)
DEPTH, 16, expected-entry FIFO depth, power of two, >=2
CNT_WIDTH, 16, width of counters and of the error index
TIMEOUT, 1024, cycles a pending entry may wait for a result; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse: clear state, enter RUN
exp_valid  in  1  expected entry offered
exp_ready  out  1  expected entry accepted when exp_valid is also high
exp_data  in  DATA_WIDTH  expected result
exp_flags  in  FLAGS_WIDTH  expected flags
exp_flags_mask  in  FLAGS_WIDTH  1 = compare that flag bit
exp_last  in  1  marks final expected entry
act_valid  in  1  result from unit under test; no backpressure
act_data  in  DATA_WIDTH  actual result
act_flags  in  FLAGS_WIDTH  actual flags
done  out  1  run complete; held until start
error  out  1  sticky, set on any error
err_code  out  3  code of first error
match_count  out  CNT_WIDTH  saturating count of matches
mismatch_count  out  CNT_WIDTH  saturating count of errors
first_err_index  out  CNT_WIDTH  compare index (0-based) of first error
first_err_exp  out  DATA_WIDTH  expected data at first error
first_err_act  out  DATA_WIDTH  actual data at first error

Behaviour:
- Reset (async, rst_n=0): state IDLE, FIFO empty, all outputs 0, exp_ready=0.
- States:
  - IDLE: start -> RUN.
  - RUN: accepts entries. Moves to DRAIN on an accepted exp_last. Moves to DONE on timeout.
  - DRAIN: exp_ready=0. Moves to DONE when the FIFO is empty and no compare is occurring this cycle, or on timeout.
  - DONE: done=1. start -> RUN.
- start in any state: clears FIFO, counters, capture registers, error and timer; next state RUN. start wins over every same-cycle event, which is discarded.
- exp_ready = (state==RUN) && !full. Push on exp_valid && exp_ready.
- Compare on act_valid in RUN or DRAIN. The result is checked against the FIFO head; the head pops the same cycle.
- Bypass: FIFO empty and a same-cycle push -> compare against the incoming entry directly; it is not stored. FIFO full with a same-cycle pop and push -> legal, count unchanged.
- Match condition: act_data==exp_data && ((act_flags ^ exp_flags) & exp_flags_mask)==0.
- Error codes:
  - 1: data mismatch (takes priority over 2)
  - 2: flags mismatch
  - 3: orphan (act_valid with FIFO empty and no bypass)
  - 4: timeout
  - 5: act_valid while in IDLE or DONE
- Every compare increments match_count or mismatch_count; codes 3-5 also increment mismatch_count. Both counters saturate at all-ones.
- First error only: err_code, first_err_index, first_err_exp and first_err_act latch; error sets. For codes 3-5, first_err_exp=0. For code 4, first_err_act=0.
- Compare index counts compares plus orphans.
- Mismatches do not stop the run.
- Timer: clears on any compare. Increments while state is RUN or DRAIN, the FIFO is non-empty and act_valid=0. Reaching TIMEOUT -> code 4, FIFO flushed, DONE next cycle.
- All outputs are registered; they update on the cycle after the triggering event.

Test Plan:
- Latency-0 bypass: start, then 8 pushes each with act_valid in the same cycle and data=i -> match_count=8, error=0, done=1 one cycle after the compare of the last entry.
- Latency-5 with full FIFO: DEPTH=16, 20 entries, results delayed 5 cycles -> exp_ready drops when full, all 20 match, no overflow, done=1.
- Flag mask: exp_flags=4'b1010, mask=4'b1000, act_flags=4'b1001 -> match. Same stimulus with mask=4'b0001 -> err_code=2, index=0.
- Data mismatch at entry 3 of 6 (exp 32'hDEAD_BEEF, act 32'hDEAD_BEEE) -> err_code=1, first_err_index=3, captures hold these values, match_count=5, mismatch_count=1.
- Timeout and orphan: TIMEOUT=10, 1 entry, no result -> err_code=4 after 10 cycles, done=1. Separate run: act_valid before any push -> err_code=3.
- Reset mid-run: rst_n low during DRAIN with 4 entries pending -> all outputs 0 immediately, FIFO empty; the next start gives a clean run.
